// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: holds a one-hot grant until the owner releases it, then rotates priority.
// Optional hold-time limit with forced release is enabled by defining GNT_TIMEOUT_EN.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 31 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: MAX_HOLD must be 2..31 and fit in CNT_W bits");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic       release_c;

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      cand = p + 2'(i);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign sel       = rr_pick(req, ptr);
  assign release_c = done | ~req[gnt_idx];

`ifdef GNT_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'b00;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'b00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= 4'b0001 << sel;
            gnt_idx   <= sel;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A normal release wins over the limit when both land on the same edge.
          if (release_c || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            timeout   <= ~release_c;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'b00;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'b00;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= 4'b0001 << sel;
            gnt_idx   <= sel;
            gnt_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (release_c) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter sharing one downstream resource among 4 requesters; the resource is, for example, the 4-to-2 encoded select path.
- Issues a one-hot grant plus its 2-bit encoded index, so the consumer can drive a mux select directly.
- Holds a grant until the owner releases it, then rotates priority so no requester starves.
- Sits between the requesting blocks and the shared datapath.

Parameters:
- MAX_HOLD, 16: maximum cycles a grant may be held (used only with GNT_TIMEOUT_EN); legal range 2..31.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  reset, asynchronous assert, active-low
- req  input  4  request per requester, level; bit i = requester i
- done  input  1  release pulse from the current owner, sampled only while busy
- gnt  output  4  one-hot grant, registered; all-zero when idle
- gnt_idx  output  2  encoded index of the set gnt bit (0..3); holds last value when idle
- gnt_valid  output  1  high when exactly one gnt bit is set
- timeout  output  1  one-cycle pulse on forced release (0 without GNT_TIMEOUT_EN)

Behaviour:
- Clock and reset: one clock domain `clk`. Reset `rst_n` is asynchronous and active-low. All state is cleared immediately when `rst_n` goes low, without waiting for a clock edge.
- Reset values: gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, state=IDLE, priority pointer ptr=2'b00, hold counter=0.
- States: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the same edge, register gnt=one-hot(sel), gnt_idx=sel, gnt_valid=1, and go to BUSY.
- Latency: req sampled high at edge k means gnt is visible after edge k, i.e. one cycle.
- BUSY, grant held: gnt, gnt_idx and gnt_valid stay constant while req[gnt_idx]=1 and done=0.
- BUSY, release condition: done=1, or req[gnt_idx]=0, or both in the same cycle (counts as a single release). At that edge:
  - gnt=0, gnt_valid=0
  - ptr=gnt_idx+1 (mod 4, so 3 wraps to 0)
  - state goes to IDLE
  - gnt_idx keeps its value
- Requests from other requesters during BUSY are ignored; they never preempt the owner.
- Dead cycle: every release is followed by at least one IDLE cycle with gnt=0 before the next grant. Minimum back-to-back spacing is therefore 1 dead cycle.
- done while IDLE is ignored.
- Rotation: the requester just released has the lowest priority at the next arbitration. With all 4 requesting continuously, the grant order is 0,1,2,3,0,...
- Invariant: gnt is always either zero or one-hot, and gnt_valid == |gnt.
- Reset mid-grant: gnt drops asynchronously and ptr returns to 0. Arbitration resumes at the first clk edge after rst_n deasserts.

Optional Feature:
- Macro: GNT_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches MAX_HOLD with no release, the arbiter force-releases: same effects as a normal release, plus timeout=1 for exactly that one cycle following the edge.
  - A normal release takes precedence over the timeout when both occur at the same edge; in that case timeout stays 0.
- Undefined: no counter is instantiated; timeout is tied to 0 and a grant may be held indefinitely.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0000, gnt_valid=0, gnt_idx=00. Release reset -> gnt=0001 after the first edge.
- Single requester: req=0100 -> gnt=0100, gnt_idx=2 one cycle later. Pulse done -> gnt=0000 next cycle. With req still 0100, gnt=0100 again one cycle after that (single-requester re-grant).
- Fairness: req=1111 held, done pulsed each time gnt is valid -> gnt_idx sequence 0,1,2,3,0, with gnt=0 for one cycle between each grant.
- No preemption and wrap: grant to 3 (req=1000). Raise req=1011 mid-grant -> gnt stays 1000. Drop req[3] -> release, ptr wraps to 0, next gnt=0001.
- Async reset mid-grant: during gnt=0010, drive rst_n=0 between clock edges -> gnt=0000 immediately, without a clock edge. After reset with req=1111 -> gnt=0001.
- GNT_TIMEOUT_EN with MAX_HOLD=4: req=0001 held, no done -> gnt deasserts after 4 BUSY cycles, timeout pulses exactly one cycle, next grant is 0001. Without the macro -> gnt=0001 held for 100 cycles and timeout stays 0.
